rr_arbiter16: RTL and testbench

Sixteen-requester round-robin arbiter that produces a registered one-hot grant vector for the 16-to-4 encoder stage directly downstream. The encoder converts `gnt` to a 4-bit index, and `gnt_valid` plays the role of its enable-out. Each grant is held until the owner signals `done`, or until a hold-timeout expires. The block guarantees the downstream encoder never sees more than one bit set.

---
 rtl/rr_arbiter16.sv | 140 ++++++++++++++
 tb/tb_rr_arbiter16.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter16.sv
// rr_arbiter16 -- sixteen-requester round-robin arbiter with hold timeout.
//
// Drives a registered one-hot (or all-zero) grant into a 16-to-4 encoder.
// A grant is held until the owner raises `done` or until the grant has lasted
// MAX_HOLD cycles (MAX_HOLD = 0 disables the limit). On release the search
// pointer moves one past the released owner and re-arbitration happens in the
// same cycle, so back-to-back grants have no idle gap.
//
// Parameters:
//   MAX_HOLD   maximum grant length in cycles (0..255, 0 = no limit)
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      synchronous active-low reset
//   req[15:0]  level-sensitive requests, bit i = requester i
//   done       owner releases the grant (only looked at while granting)
//   gnt[15:0]  registered grant, one-hot or zero
//   gnt_valid  registered, high exactly when gnt is non-zero
//   timeout    registered one-cycle pulse when a grant is forcibly released
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [7:0]  hcnt, hcnt_nxt;
  logic [15:0] gnt_nxt;
  logic        gnt_valid_nxt;
  logic        timeout_nxt;

  logic [3:0]  cur_idx;
  logic [3:0]  rel_ptr;
  logic        limit_hit;
  logic        release_now;

  // First set bit of r scanning upward from p, wrapping 15 -> 0.
  function automatic logic [15:0] pick(input logic [15:0] r, input logic [3:0] p);
    logic [15:0] sel;
    logic [3:0]  idx;
    sel = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = p + 4'(k);
      if (r[idx] && (sel == '0)) sel[idx] = 1'b1;
    end
    return sel;
  endfunction

  // Index of the (single) set bit of a one-hot vector.
  function automatic logic [3:0] enc(input logic [15:0] g);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (g[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hcnt_nxt    = hcnt;
    gnt_nxt     = gnt;
    timeout_nxt = 1'b0;

    cur_idx     = enc(gnt);
    rel_ptr     = cur_idx + 4'd1;
    limit_hit   = HOLD_EN && (hcnt == HOLD_LIM);
    release_now = done || limit_hit;

    case (state)
      IDLE: begin
        if (req != '0) begin
          gnt_nxt   = pick(req, ptr);
          hcnt_nxt  = 8'd1;
          state_nxt = GRANT;
        end else begin
          gnt_nxt = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Pointer moves past the released owner before re-arbitrating, so
          // the old owner only wins again when nobody else is requesting.
          ptr_nxt     = rel_ptr;
          timeout_nxt = !done && limit_hit;
          gnt_nxt     = pick(req, rel_ptr);
          if (req != '0) begin
            hcnt_nxt  = 8'd1;
            state_nxt = GRANT;
          end else begin
            hcnt_nxt  = '0;
            state_nxt = IDLE;
          end
        end else if (hcnt != '1) begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase

    gnt_valid_nxt = (gnt_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hcnt      <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hcnt      <= hcnt_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Testbench for rr_arbiter16 (MAX_HOLD = 4): directed stimulus, a behavioural
// owner/pointer/count model checked every cycle, and literal expectations.
module tb_rr_arbiter16;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter16 #(.MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Model: who owns the grant (-1 = nobody), where the search starts,
  // how many cycles the current grant has lasted, and the timeout pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;
  bit started = 1'b0;

  function automatic int pick_m(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      int i;
      i = (p + k) % 16;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
      started = 1'b1;
    end else if (m_owner < 0) begin
      m_to    = 1'b0;
      m_owner = pick_m(req, m_ptr);
      m_cnt   = (m_owner >= 0) ? 1 : 0;
    end else begin
      bit lim;
      lim = (HOLD != 0) && (m_cnt == HOLD);
      if (done || lim) begin
        m_to    = !done && lim;
        m_ptr   = (m_owner + 1) % 16;
        m_owner = pick_m(req, m_ptr);
        m_cnt   = (m_owner >= 0) ? 1 : 0;
      end else begin
        m_to  = 1'b0;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic [15:0] exp_g;
      exp_g = '0;
      if (m_owner >= 0) exp_g[m_owner] = 1'b1;
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL model_gnt t=%0t: got %h expected %h", $time, gnt, exp_g);
      end
      checks++;
      if (gnt_valid !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL model_valid t=%0t: got %b expected %b", $time, gnt_valid, m_owner >= 0);
      end
      checks++;
      if (timeout !== m_to) begin
        errors++;
        $display("FAIL model_timeout t=%0t: got %b expected %b", $time, timeout, m_to);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [15:0] eg, input logic ev, input logic et);
    chk({name, "_gnt"}, gnt, eg);
    chk({name, "_valid"}, {15'd0, gnt_valid}, {15'd0, ev});
    chk({name, "_timeout"}, {15'd0, timeout}, {15'd0, et});
  endtask

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0;
    cyc(); cyc();
    chk_out("reset", 16'h0000, 1'b0, 1'b0);

    // Single request, then done with nothing pending.
    rst_n = 1'b1; req = 16'h0001;
    cyc();
    chk_out("first_grant", 16'h0001, 1'b1, 1'b0);
    req = 16'h0000; done = 1'b1;
    cyc();
    chk_out("done_to_idle", 16'h0000, 1'b0, 1'b0);

    // Fresh reset, then all requesting with done every cycle.
    rst_n = 1'b0; done = 1'b0;
    cyc();
    rst_n = 1'b1; req = 16'hFFFF; done = 1'b1;
    for (int k = 0; k < 32; k++) begin
      logic [15:0] e;
      cyc();
      e = '0;
      e[k % 16] = 1'b1;
      chk($sformatf("walk_%0d", k), gnt, e);
    end

    // Owner 15 releases: wrap to the lowest pending index, pointer then 3.
    req = 16'h8004;
    cyc();
    chk("wrap_grant", gnt, 16'h0004);
    req = 16'hFFFF;
    cyc();
    chk("ptr_after_wrap", gnt, 16'h0008);

    // Go idle with pointer 4, then hold without done until the limit.
    req = 16'h0000;
    cyc();
    chk_out("idle_again", 16'h0000, 1'b0, 1'b0);
    req = 16'h0030; done = 1'b0;
    for (int k = 1; k <= HOLD; k++) begin
      cyc();
      chk_out($sformatf("hold_%0d", k), 16'h0010, 1'b1, 1'b0);
    end
    cyc();
    chk_out("timeout_handover", 16'h0020, 1'b1, 1'b1);
    for (int k = 2; k <= HOLD; k++) begin
      cyc();
      chk_out($sformatf("hold2_%0d", k), 16'h0020, 1'b1, 1'b0);
    end
    // done on the limit cycle wins over the timeout.
    done = 1'b1;
    cyc();
    chk_out("done_beats_limit", 16'h0010, 1'b1, 1'b0);

    // Owner drops its request; grant persists until the timeout.
    req = 16'h0000;
    cyc();
    req = 16'h0100; done = 1'b0;
    cyc();
    chk("drop_start", gnt, 16'h0100);
    req = 16'h0000;
    for (int k = 2; k <= HOLD; k++) begin
      cyc();
      chk($sformatf("drop_hold_%0d", k), gnt, 16'h0100);
    end
    cyc();
    chk_out("drop_timeout_idle", 16'h0000, 1'b0, 1'b1);
    cyc();
    chk_out("drop_idle_next", 16'h0000, 1'b0, 1'b0);

    // done while idle does nothing.
    done = 1'b1;
    cyc();
    chk_out("done_in_idle", 16'h0000, 1'b0, 1'b0);
    done = 1'b0;

    // Reset in the middle of a grant.
    req = 16'h0400;
    cyc();
    chk("pre_reset_grant", gnt, 16'h0400);
    req = 16'hFFFF; rst_n = 1'b0;
    cyc();
    chk_out("mid_reset", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk_out("after_reset", 16'h0001, 1'b1, 1'b0);
    req = 16'h0000; done = 1'b1;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
